// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment scan driver:
//   - segment patterns, bit order {g,f,e,d,c,b,a}, active-low
//   - 16-entry glyph table (0..9 digits, 10..15 dash)
//   - scan slot enumeration and the active-low anode pattern per slot
// Optional feature macro used by the top: LEADING_ZERO_BLANK_EN
// ----------------------------------------------------------------------------
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Glyphs indexed by the 4-bit code; out-of-range BCD shows a dash.
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    SEG_DASH,    // A
    SEG_DASH,    // B
    SEG_DASH,    // C
    SEG_DASH,    // D
    SEG_DASH,    // E
    SEG_DASH     // F
  };

  // Scan slot; slot 0 is the rightmost digit.
  typedef enum logic [1:0] {
    SLOT_ONES = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_2    = 2'd2,
    SLOT_3    = 2'd3
  } slot_e;

  localparam logic [3:0] AN_IDLE = 4'b1111;

  localparam logic [3:0] AN_SEL [4] = '{
    4'b1110,
    4'b1101,
    4'b1011,
    4'b0111
  };

  function automatic logic [3:0] anode_for(input slot_e s);
    return AN_SEL[s];
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// ----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational 4-bit code to 7-segment glyph lookup (active-low).
// Ports:
//   bcd  in  4  digit code; 10..15 render as a dash
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
// ----------------------------------------------------------------------------
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH[bcd];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexes two BCD digits onto a 4-digit common-anode 7-segment
// display. Digits are snapshotted once per scan frame so a frame never mixes
// old and new values.
// Parameters:
//   SCAN_DIV    clk cycles per digit slot (>= 2)
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous, active-high reset
//   digit1      in   4  BCD ones digit
//   digit2      in   4  BCD tens digit
//   hold        in   1  1 = skip snapshots (display freezes)
//   an          out  4  anode enables, active-low, an[0] = rightmost
//   seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal point, active-low, always off
//   frame_tick  out  1  one-cycle pulse marking a snapshot
// Configuration macro:
//   LEADING_ZERO_BLANK_EN  blank the tens slot when the tens digit is 0
// ----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic       hold,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  slot_e         idx_q, idx_d;
  logic [3:0]    snap_lo_q, snap_lo_d;
  logic [3:0]    snap_hi_q, snap_hi_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_tick_q, frame_tick_d;

  logic          tick;
  logic          take_snap;
  logic [3:0]    slot_digit;
  logic [6:0]    slot_glyph;

  assign tick      = (cnt_q == CNT_LAST);
  // Snapshot only on the slot-3 -> slot-0 boundary, so each frame is coherent.
  assign take_snap = tick && (idx_q == SLOT_3) && !hold;

  // Single shared decoder; only the two digit slots ever use its output.
  always_comb begin
    slot_digit = (idx_q == SLOT_TENS) ? snap_hi_q : snap_lo_q;
  end

  bcd_to_seg7 u_dec (
    .bcd (slot_digit),
    .seg (slot_glyph)
  );

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = tick ? slot_e'(idx_q + 2'd1) : idx_q;
    snap_lo_d    = snap_lo_q;
    snap_hi_d    = snap_hi_q;
    frame_tick_d = take_snap;
    if (take_snap) begin
      snap_lo_d = digit1;
      snap_hi_d = digit2;
    end

    // Output registers decode the current slot, so they trail idx by one clk.
    an_d = anode_for(idx_q);
    case (idx_q)
      SLOT_ONES: seg_d = slot_glyph;
      SLOT_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
        seg_d = (snap_hi_q == 4'd0) ? SEG_BLANK : slot_glyph;
`else
        seg_d = slot_glyph;
`endif
      end
      default:   seg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= SLOT_ONES;
      snap_lo_q    <= '0;
      snap_hi_q    <= '0;
      an_q         <= AN_IDLE;
      seg_q        <= SEG_BLANK;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_lo_q    <= snap_lo_d;
      snap_hi_q    <= snap_hi_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int D   = 4;
  localparam int CYC = 5;
  localparam int FRAME = 4 * D;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit1, digit2;
  logic       hold;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  always #CYC clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .digit1     (digit1),
    .digit2     (digit2),
    .hold       (hold),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: n = rising edges since reset release.
  int         n;
  logic [3:0] m_lo, m_hi;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_ft;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t n=%0d)", name, act, exp, $time, n);
    end
  endtask

  task automatic model_reset();
    n = 0; m_lo = 4'd0; m_hi = 4'd0; e_ft = 1'b0;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    int slot;
    @(posedge clk);
    n++;
    slot = ((n - 1) / D) % 4;
    e_an = ~(4'b0001 << slot);
    if (slot == 0)      e_seg = glyph(m_lo);
    else if (slot == 1) e_seg = (LZB && m_hi == 4'd0) ? 7'h7F : glyph(m_hi);
    else                e_seg = 7'h7F;
    if ((n % FRAME) == 0 && !hold) begin
      m_lo = digit1; m_hi = digit2; e_ft = 1'b1;
    end else begin
      e_ft = 1'b0;
    end
    #1;
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("frame_tick", frame_tick, e_ft);
    check("an_onehot", $countones(~an), 1);
    check("dp", dp, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"}, an, 4'b1111);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp"}, dp, 1);
    check({tag, "_ft"}, frame_tick, 0);
  endtask

  typedef struct {
    logic [3:0] d1;
    logic [3:0] d2;
    logic [6:0] exp_ones;
    logic [6:0] exp_tens;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int k, ft_cnt, last_ft;
    vecs[0] = '{4'hC, 4'h0, 7'b0111111, LZB ? 7'b1111111 : 7'b1000000};
    vecs[1] = '{4'h0, 4'h9, 7'b1000000, 7'b0010000};
    vecs[2] = '{4'h2, 4'h4, 7'b0100100, 7'b0011001};
    vecs[3] = '{4'hF, 4'hA, 7'b0111111, 7'b0111111};
    vecs[4] = '{4'h6, 4'h1, 7'b0000010, 7'b1111001};

    // 1. reset, release with 3/7
    rst = 1'b1; digit1 = 4'd3; digit2 = 4'd7; hold = 1'b0;
    model_reset();
    #2;
    check_reset_vals("rst_async");
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_held");
    rst = 1'b0;
    step();
    check("rel_an", an, 4'b1110);
    check("rel_seg", seg, 7'b1000000);
    repeat (15) step();
    check("first_ft", frame_tick, 1);
    step();
    check("ones3", seg, 7'b0110000);
    repeat (4) step();
    check("tens7", seg, 7'b1111000);

    // 2. free run 3 frames, measure frame_tick period
    ft_cnt = 0; last_ft = -1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (frame_tick) begin
        if (last_ft >= 0) check("ft_period", n - last_ft, FRAME);
        last_ft = n;
        ft_cnt++;
      end
    end
    check("ft_count3", ft_cnt, 3);

    // 3. change digit1 during idx1
    k = 0;
    do begin step(); k++; end while (((n / D) % 4) != 1 && k < 20);
    check("reach_idx1", (n / D) % 4, 1);
    digit1 = 4'd5;
    k = 0;
    do begin
      step(); k++;
      if (an == 4'b1110) check("still3", seg, 7'b0110000);
    end while (!frame_tick && k < 40);
    check("ft_after_change", frame_tick, 1);
    step();
    check("ones5", seg, 7'b0010010);

    // 4. hold across two boundaries
    hold = 1'b1;
    ft_cnt = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      if (i % 5 == 0) begin digit1 = 4'(i % 10); digit2 = 4'((i + 3) % 10); end
      step();
      if (frame_tick) ft_cnt++;
      if (an == 4'b1110) check("frozen_ones", seg, 7'b0010010);
    end
    check("hold_no_ft", ft_cnt, 0);
    hold = 1'b0; digit1 = 4'd8; digit2 = 4'd6;
    k = 0;
    do begin step(); k++; end while (!frame_tick && k < 40);
    check("ft_after_hold", frame_tick, 1);
    step();
    check("ones8", seg, 7'b0000000);

    // 5. table of glyph vectors (incl. dash and tens zero)
    foreach (vecs[v]) begin
      digit1 = vecs[v].d1; digit2 = vecs[v].d2;
      k = 0;
      do begin step(); k++; end while (!frame_tick && k < 40);
      check("vec_ft", frame_tick, 1);
      step();
      check("vec_ones", seg, vecs[v].exp_ones);
      repeat (4) step();
      check("vec_tens", seg, vecs[v].exp_tens);
    end

    // randomized run against the model
    for (int i = 0; i < 300; i++) begin
      digit1 = 4'($urandom_range(15, 0));
      digit2 = 4'($urandom_range(15, 0));
      hold   = ($urandom_range(3, 0) == 0);
      step();
    end
    hold = 1'b0;

    // 6. reset during slot idx2
    k = 0;
    do begin step(); k++; end while (an != 4'b1011 && k < 20);
    check("reach_idx2", an, 4'b1011);
    #2 rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_mid_held");
    rst = 1'b0;
    model_reset();
    step();
    check("rel2_an", an, 4'b1110);
    check("rel2_seg", seg, 7'b1000000);
    repeat (2 * FRAME) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
